// File: rtl/rect_motion_ctl.sv
// Frame-synchronous rectangle position sequencer: steps the overlay position once per
// FRAME_DIV frames at the start of vertical blanking and bounces off the active-area edges.
module rect_motion_ctl #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int RECT_W    = 48,
  parameter int RECT_H    = 64,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 0,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        enable,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        update,
  output logic        corner
);

  localparam logic [12:0] XMAX   = 13'(H_ACTIVE - RECT_W);
  localparam logic [12:0] YMAX   = 13'(V_ACTIVE - RECT_H);
  localparam logic [12:0] STEPX  = 13'(STEP_X);
  localparam logic [12:0] STEPY  = 13'(STEP_Y);
  localparam logic [7:0]  FLAST  = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPD} state_t;

  state_t      r_state;
  logic [7:0]  r_fcnt;
  logic        r_vblnk_d;
  logic [11:0] r_xpos;
  logic [11:0] r_ypos;
  logic        r_dir_x;
  logic        r_dir_y;
  logic        r_update;
  logic        r_corner;
  logic        w_tick;
  logic [13:0] w_xs;
  logic [13:0] w_ys;

  // One axis move in 13-bit arithmetic; returns {bounce, reversed_dir, new_pos}.
  // dir_rev = 0 moves toward the far edge (right/down), 1 toward zero.
  function automatic logic [13:0] axis_step(input logic [12:0] pos, input logic [12:0] step,
                                            input logic [12:0] lim, input logic dir_rev);
    logic [12:0] sum;
    logic [12:0] dif;
    sum = pos + step;
    dif = pos - step;
    if (!dir_rev) begin
      if (sum >= lim) axis_step = {1'b1, 1'b1, lim[11:0]};
      else            axis_step = {1'b0, 1'b0, sum[11:0]};
    end else begin
      if (pos <= step) axis_step = {1'b1, 1'b0, 12'd0};
      else             axis_step = {1'b0, 1'b1, dif[11:0]};
    end
  endfunction

  assign w_tick = vblnk_in & ~r_vblnk_d;

  always_comb begin
    w_xs = axis_step({1'b0, r_xpos}, STEPX, XMAX, r_dir_x);
    w_ys = axis_step({1'b0, r_ypos}, STEPY, YMAX, r_dir_y);
  end

  // vblnk_d resets high so a blank already in progress at reset release is not a tick.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_fcnt    <= 8'd0;
      r_vblnk_d <= 1'b1;
      r_xpos    <= 12'(X_INIT);
      r_ypos    <= 12'(Y_INIT);
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
      r_update  <= 1'b0;
      r_corner  <= 1'b0;
    end else begin
      r_vblnk_d <= vblnk_in;
      r_update  <= 1'b0;
      r_corner  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fcnt <= 8'd0;
          if (enable) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_fcnt  <= 8'd0;
          end else if (w_tick) begin
            if (r_fcnt == FLAST) begin
              r_state <= S_UPD;
              r_fcnt  <= 8'd0;
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
        end
        S_UPD: begin
          r_xpos   <= w_xs[11:0];
          r_dir_x  <= w_xs[12];
          r_ypos   <= w_ys[11:0];
          r_dir_y  <= w_ys[12];
          r_update <= 1'b1;
          r_corner <= w_xs[13] & w_ys[13];
          r_state  <= S_WAIT;
        end
        default: begin
          r_state <= S_IDLE;
          r_fcnt  <= 8'd0;
        end
      endcase
    end
  end

  assign xpos   = r_xpos;
  assign ypos   = r_ypos;
  assign update = r_update;
  assign corner = r_corner;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Scoreboard bench for rect_motion_ctl: four parameterisations share one blanking/enable
// stream; expected updates are queued at each tick and matched by a negedge monitor.
module tb_rect_motion_ctl;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        enable;
  logic [11:0] xo [4];
  logic [11:0] yo [4];
  logic        up [4];
  logic        co [4];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q [4][$];

  int INIT_X [4] = '{0, 750, 750, 2};
  int INIT_Y [4] = '{0, 0, 534, 0};
  int DX     [5] = '{6, 8, 4, 0, 4};

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Defaults
  rect_motion_ctl u_a (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .enable(enable),
    .xpos(xo[0]), .ypos(yo[0]), .update(up[0]), .corner(co[0]));

  // Right-edge bounce
  rect_motion_ctl #(.X_INIT(750), .STEP_X(4)) u_b (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .enable(enable),
    .xpos(xo[1]), .ypos(yo[1]), .update(up[1]), .corner(co[1]));

  // Corner bounce
  rect_motion_ctl #(.X_INIT(750), .Y_INIT(534), .STEP_X(4), .STEP_Y(4)) u_c (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .enable(enable),
    .xpos(xo[2]), .ypos(yo[2]), .update(up[2]), .corner(co[2]));

  // Narrow area (XMAX = 8) with a frame divider of 3
  rect_motion_ctl #(.H_ACTIVE(56), .X_INIT(2), .STEP_X(4), .FRAME_DIV(3)) u_d (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .enable(enable),
    .xpos(xo[3]), .ypos(yo[3]), .update(up[3]), .corner(co[3]));

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  // Expected results of the n-th tick after enabling; update lands one edge after the tick edge.
  task automatic push_tick(input int n);
    int t;
    t = cyc + 2;
    q[0].push_back(exp_t'{n, n, 0, t});
    q[1].push_back(exp_t'{752 - 4 * (n - 1), n, 0, t});
    q[2].push_back(exp_t'{752 - 4 * (n - 1), 536 - 4 * (n - 1), (n == 1) ? 1 : 0, t});
    if ((n % 3 == 0) && (n <= 15)) q[3].push_back(exp_t'{DX[n / 3 - 1], n / 3, 0, t});
  endtask

  task automatic frame(input bit push, input int n);
    vblnk = 1'b0;
    repeat (8) @(negedge pclk);
    vblnk = 1'b1;
    if (push) push_tick(n);
    repeat (4) @(negedge pclk);
  endtask

  task automatic chk_pos(input string tag, input int i, input int ex, input int ey);
    chk($sformatf("%s_x%0d", tag, i), int'(xo[i]), ex);
    chk($sformatf("%s_y%0d", tag, i), int'(yo[i]), ey);
  endtask

  always @(negedge pclk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (up[i]) begin
        if (q[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_update%0d: got update at cycle %0d want none", i, cyc);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("upd_x%0d", i), int'(xo[i]), e.x);
          chk($sformatf("upd_y%0d", i), int'(yo[i]), e.y);
          chk($sformatf("upd_corner%0d", i), int'(co[i]), e.c);
          chk($sformatf("upd_cycle%0d", i), cyc, e.t);
        end
      end else if (co[i]) begin
        total++;
        bad++;
        $display("FAIL corner_alone%0d: got corner=1 without update want 0", i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    vblnk  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      chk_pos("rst", i, INIT_X[i], INIT_Y[i]);
      chk($sformatf("rst_upd%0d", i), int'(up[i]), 0);
      chk($sformatf("rst_corner%0d", i), int'(co[i]), 0);
    end
    rst = 1'b0;

    repeat (3) frame(1'b0, 0);
    for (int i = 0; i < 4; i++) chk_pos("hold", i, INIT_X[i], INIT_Y[i]);

    enable = 1'b1;
    for (int n = 1; n <= 15; n++) frame(1'b1, n);
    repeat (4) @(negedge pclk);

    // enable dropped in the tick cycle: no update
    vblnk = 1'b0;
    repeat (8) @(negedge pclk);
    vblnk  = 1'b1;
    enable = 1'b0;
    repeat (6) @(negedge pclk);
    chk_pos("race", 0, 15, 15);
    chk_pos("race", 3, 4, 5);

    // tick in the same cycle as leaving IDLE: no update
    vblnk = 1'b0;
    repeat (4) @(negedge pclk);
    enable = 1'b1;
    vblnk  = 1'b1;
    repeat (6) @(negedge pclk);
    chk_pos("reen", 0, 15, 15);
    chk_pos("reen", 2, 696, 480);

    frame(1'b1, 16);
    repeat (4) @(negedge pclk);
    chk_pos("f16", 1, 692, 16);

    // asynchronous reset while in UPDATE
    vblnk = 1'b0;
    repeat (8) @(negedge pclk);
    vblnk = 1'b1;
    @(posedge pclk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_pos("arst", i, INIT_X[i], INIT_Y[i]);
      chk($sformatf("arst_upd%0d", i), int'(up[i]), 0);
    end
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    repeat (10) @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      chk_pos("post", i, INIT_X[i], INIT_Y[i]);
      chk($sformatf("pending%0d", i), q[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rect_motion_ctl.md
# rect_motion_ctl

Frame-synchronous position sequencer for the rectangle overlay stage. It watches the blanking signal from the VGA timing generator and computes a new rectangle position once per N frames. It advances the position by a fixed step and bounces off the active-area edges. Positions change only at the start of vertical blanking, so the rectangle drawer never renders a torn frame.

## Interface
- H_ACTIVE, 800: active pixels per line.
- V_ACTIVE, 600: active lines per frame.
- RECT_W, 48: rectangle width; XMAX = H_ACTIVE-RECT_W = 752.
- RECT_H, 64: rectangle height; YMAX = V_ACTIVE-RECT_H = 536.
- X_INIT, 0 / Y_INIT, 0: reset position; must be ≤ XMAX / YMAX.
- STEP_X, 1 / STEP_Y, 1: pixels moved per update; must be ≥ 1.
- FRAME_DIV, 1: frames per update, range 1..255.

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- vblnk_in  in  1  vertical blanking from vga_timing.
- enable  in  1  level; motion runs while high.
- xpos  out  12  rectangle left edge, registered.
- ypos  out  12  rectangle top edge, registered.
- update  out  1  one-cycle pulse when xpos/ypos change.
- corner  out  1  one-cycle pulse when both axes bounce in the same update.

## Operation
- Frame tick: tick = vblnk_in & ~vblnk_d, where vblnk_d is vblnk_in registered.
  - vblnk_d resets to 1, so a blank already in progress at reset release never produces a tick.
- State machine with 8-bit frame counter fcnt.
  - IDLE: outputs hold; fcnt = 0. Goes to WAIT when enable = 1.
  - WAIT, enable = 0: go to IDLE and clear fcnt.
  - WAIT, tick with fcnt == FRAME_DIV-1: go to UPDATE and clear fcnt.
  - WAIT, tick otherwise: increment fcnt and stay in WAIT.
  - UPDATE: load the new position and directions, pulse update, return to WAIT unconditionally. enable is ignored in this state; the update always completes.
- X axis, dir_x = right (reset value):
  - if x+STEP_X ≥ XMAX: x = XMAX, dir_x = left, bounce_x = 1.
  - else x = x+STEP_X.
- X axis, dir_x = left:
  - if x ≤ STEP_X: x = 0, dir_x = right, bounce_x = 1.
  - else x = x-STEP_X.
- Y axis: same rules using YMAX, STEP_Y and dir_y. Down is the reset direction; up is the reverse.
- corner = bounce_x & bounce_y.
- Arithmetic is 13-bit unsigned, so the compare cannot overflow. Results are always within 0..XMAX and 0..YMAX.
- Entering WAIT from IDLE does not fire on a tick in that same cycle. The first move needs a rising vblnk edge observed while in WAIT.

## Timing
- Reset values:
  - xpos = X_INIT, ypos = Y_INIT.
  - update = 0, corner = 0.
  - dir_x = right, dir_y = down.
  - fcnt = 0, state = IDLE, vblnk_d = 1.
- Latency: the tick is detected at the posedge where vblnk_in is first sampled high (cycle k); the FSM enters UPDATE at that edge.
  - xpos, ypos, update and corner change at edge k+1.
  - update and corner are high for exactly one cycle.
- Minimum spacing between updates is one frame. With FRAME_DIV = D, updates land on every D-th tick.
- An enable deassert in the same cycle as a tick has priority: go to IDLE, no update.
- An asynchronous rst asserted mid-UPDATE forces all reset values immediately; there is no partial position load.
- xpos and ypos are stable from edge k+1 until the next update, which covers the whole active frame.

## Test plan
- Reset/hold: assert rst with vblnk_in = 1, release, keep enable = 0 for 3 frames → xpos = 0, ypos = 0, no update pulse.
- Basic step: enable = 1 with defaults; run 3 frames → update pulses once per frame, 1 cycle after each vblnk rise; positions (1,1), (2,2), (3,3).
- Right-edge bounce: X_INIT = 750, STEP_X = 4 → x = 752 with dir left (corner = 0), then x = 748.
- Corner: X_INIT = 750, Y_INIT = 534, STEP = 4 → (752,536) with a one-cycle corner pulse, then (748,532).
- Left edge and divider: X_INIT = 2, dir left after a bounce, FRAME_DIV = 3 → update only on every 3rd tick; x = 2 → 0 with dir right, then x = 4.
- Enable race and async reset: drop enable on the tick cycle → no update and state IDLE; assert rst during UPDATE → xpos = X_INIT and update = 0 immediately.
